// File: rtl/demux1x4_stream.sv
// demux1x4_stream
// Registered 1-to-4 stream demultiplexer. One input stream (data plus a
// 2-bit channel select) is steered into one of four single-entry output
// slots, each with its own valid/ready handshake toward an independent
// consumer. A per-channel wrapping counter tallies output transfers.
//
// Handshake summary:
//   - in_ready looks only at the addressed channel, so a stalled channel
//     never blocks traffic aimed at the others.
//   - A slot that drains on the same edge it is reloaded stays valid and
//     takes the new word, giving one word per cycle into a channel whose
//     consumer keeps ready high.
//   - out_data of a channel is only written on a load, so it holds steady
//     while stalled and keeps its last word after draining.
module demux1x4_stream #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_sel,
  input  logic [WIDTH-1:0]     in_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [4*CNT_W-1:0]   xfer_cnt,
  output logic                 busy
);

  localparam int NCH = 4;

  // Registered state
  logic [NCH-1:0]       valid_r;
  logic [NCH*WIDTH-1:0] data_r;
  logic [NCH*CNT_W-1:0] cnt_r;
  logic                 busy_r;

  // Per-cycle decisions
  logic                 accept_s;
  logic [NCH-1:0]       sel_onehot_s;
  logic [NCH-1:0]       load_s;
  logic [NCH-1:0]       drain_s;
  logic [NCH-1:0]       valid_nxt_s;

  // One-hot decode of the channel select; every 2-bit code is a legal channel.
  function automatic logic [3:0] sel_decode(input logic [1:0] sel);
    logic [3:0] onehot;
    case (sel)
      2'd0:    onehot = 4'b0001;
      2'd1:    onehot = 4'b0010;
      2'd2:    onehot = 4'b0100;
      2'd3:    onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

  // Input-side readiness and accept: only the addressed slot matters.
  always_comb begin
    in_ready     = 1'b0;
    accept_s     = 1'b0;
    sel_onehot_s = sel_decode(in_sel);
    if (~valid_r[in_sel] | out_ready[in_sel]) begin
      in_ready = 1'b1;
    end else begin
      in_ready = 1'b0;
    end
    accept_s = in_valid & in_ready;
  end

  // Per-channel load/drain strobes and next-cycle slot occupancy.
  always_comb begin
    load_s      = '0;
    drain_s     = '0;
    valid_nxt_s = '0;
    for (int k = 0; k < NCH; k++) begin
      load_s[k]      = accept_s & sel_onehot_s[k];
      drain_s[k]     = valid_r[k] & out_ready[k];
      // A reload on the draining edge keeps the slot occupied.
      valid_nxt_s[k] = load_s[k] | (valid_r[k] & ~drain_s[k]);
    end
  end

  // Slot occupancy flags and the registered busy summary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      busy_r  <= 1'b0;
    end else begin
      valid_r <= valid_nxt_s;
      busy_r  <= |valid_nxt_s;
    end
  end

  // Slot data: written only on a load so stalled or drained words stay put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (load_s[k]) begin
          data_r[k*WIDTH +: WIDTH] <= in_data;
        end else begin
          data_r[k*WIDTH +: WIDTH] <= data_r[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Output-transfer counters, free-running wrap with no overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (drain_s[k]) begin
          cnt_r[k*CNT_W +: CNT_W] <= cnt_r[k*CNT_W +: CNT_W] + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_r[k*CNT_W +: CNT_W] <= cnt_r[k*CNT_W +: CNT_W];
        end
      end
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign xfer_cnt  = cnt_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_demux1x4_stream.sv
// tb_demux1x4_stream
// Scoreboard bench: each accepted word is pushed onto its channel's queue
// and popped/compared when that channel transfers. Inputs change on the
// falling edge; outputs are sampled before the rising edge and after the
// following falling edge.
module tb_demux1x4_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [3:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
  logic [31:0] xfer_cnt;
  logic        busy;

  int          n_checks;
  int          n_fail;

  // Reference model
  logic [3:0]  sb [4][$];
  logic [3:0]  mlast [4];
  logic [7:0]  mcnt [4];

  demux1x4_stream #(.WIDTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .xfer_cnt  (xfer_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      sb[k].delete();
      mlast[k] = 4'h0;
      mcnt[k]  = 8'h00;
    end
  endtask

  task automatic check_state();
    logic any_v;
    any_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("valid%0d", k), 32'(out_valid[k]), 32'(sb[k].size() != 0));
      check($sformatf("data%0d", k), 32'(out_data[k*4 +: 4]), 32'(mlast[k]));
      check($sformatf("cnt%0d", k), 32'(xfer_cnt[k*8 +: 8]), 32'(mcnt[k]));
      if (sb[k].size() != 0) any_v = 1'b1;
    end
    check("busy", 32'(busy), 32'(any_v));
  endtask

  // One clock cycle: drive, predict, clock, check. Called just after a falling edge.
  task automatic step(input logic v, input logic [1:0] sel, input logic [3:0] d,
                      input logic [3:0] rdy);
    logic       exp_ready;
    logic [3:0] exp_w;
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = rdy;
    #1;
    exp_ready = (sb[sel].size() == 0) || rdy[sel];
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    for (int k = 0; k < 4; k++) begin
      if (sb[k].size() != 0 && rdy[k]) begin
        exp_w = sb[k].pop_front();
        check($sformatf("drain%0d", k), 32'(out_data[k*4 +: 4]), 32'(exp_w));
        mcnt[k] = mcnt[k] + 8'd1;
      end
    end
    if (v && exp_ready) begin
      sb[sel].push_back(d);
      mlast[sel] = d;
    end
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_cnt", xfer_cnt, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    model_clear();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_state();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 4'h0;
    out_ready = 4'b0000;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_state();

    // Reset mid-stream with channel 2 holding a word.
    step(1'b1, 2'd2, 4'h7, 4'b0000);
    step(1'b0, 2'd0, 4'h0, 4'b0000);
    check("pre_rst_v2", 32'(out_valid[2]), 32'h1);
    async_reset();

    // Steering 4'b1010 to each channel with all consumers ready.
    for (int k = 0; k < 4; k++) step(1'b1, 2'(k), 4'b1010, 4'b1111);
    step(1'b0, 2'd0, 4'h0, 4'b1111);
    for (int k = 0; k < 4; k++)
      check($sformatf("steer_cnt%0d", k), 32'(xfer_cnt[k*8 +: 8]), 32'h1);

    // Backpressure on channel 1.
    step(1'b1, 2'd1, 4'hA, 4'b0000);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 4'hB, 4'b0000);
    check("bp_hold", 32'(out_data[7:4]), 32'hA);
    step(1'b1, 2'd1, 4'hB, 4'b0010);
    check("bp_newword", 32'(out_data[7:4]), 32'hB);

    // Independence: channel 1 still stalled, send to channel 3.
    step(1'b1, 2'd3, 4'h5, 4'b0000);
    check("ind_v3", 32'(out_valid[3]), 32'h1);
    check("ind_d1", 32'(out_data[7:4]), 32'hB);
    step(1'b0, 2'd0, 4'h0, 4'b1010);

    // Streaming 8 words into channel 0.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'd0, 4'(i + 3), 4'b0001);
      check("stream_v0", 32'(out_valid[0]), 32'h1);
    end
    step(1'b0, 2'd0, 4'h0, 4'b0001);
    check("stream_cnt0", 32'(xfer_cnt[7:0]), 32'h9);

    // Mixed random traffic.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(1)), 2'($urandom_range(3)), 4'($urandom_range(15)),
           4'($urandom_range(15)));

    // Counter wrap on channel 2 from a fresh reset.
    async_reset();
    for (int i = 0; i < 256; i++) step(1'b1, 2'd2, 4'(i), 4'b0100);
    step(1'b0, 2'd0, 4'h0, 4'b0100);
    check("wrap_cnt2", 32'(xfer_cnt[23:16]), 32'h0);
    check("wrap_others", 32'({xfer_cnt[31:24], xfer_cnt[15:0]}), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
